watch_timekeeper: RTL
=====================

# watch_timekeeper

Real-time-of-day core for `homegrown_watch`: divides the system clock down to a 1 Hz tick and keeps a 24-hour BCD time (HH:MM:SS). It sits directly upstream of the display/pad-driver logic, which consumes `time_o` and `tick_o` to drive the seven-segment outputs on `io_out`. Time is set through a valid-strobe load port driven from logic-analyzer or pad inputs. An optional alarm compares the running time against a programmed value.

## Interface
- `CLK_HZ`, default 10_000_000: `wb_clk_i` cycles per second; prescaler terminal count is `CLK_HZ-1`; must be ≥ 2.
- `wb_clk_i`  in  1  single clock; all state on rising edge.
- `wb_rst_ni`  in  1  reset, asynchronous assert, active-low.
- `run_i`  in  1  1 = count; 0 = prescaler and time frozen.
- `set_valid_i`  in  1  single-cycle load strobe for `set_time_i`.
- `set_time_i`  in  24  BCD `{H1,H0,M1,M0,S1,S0}`, 4 bits per digit.
- `set_err_o`  out  1  one-cycle pulse when a load is rejected as out of range.
- `time_o`  out  24  current BCD time, same packing as `set_time_i`.
- `tick_o`  out  1  one-cycle pulse; seconds advanced on the previous edge.
- `rollover_o`  out  1  one-cycle pulse coincident with `tick_o` when 23:59:59 wraps to 00:00:00.
- `alarm_time_i`  in  24  BCD alarm time (only with `WATCH_ALARM_EN`).
- `alarm_en_i`  in  1  arm the alarm (only with `WATCH_ALARM_EN`).
- `alarm_ack_i`  in  1  silence the ringing alarm (only with `WATCH_ALARM_EN`).
- `alarm_o`  out  1  high while ringing (only with `WATCH_ALARM_EN`).

## Operation
- Reset: prescaler = 0, `time_o` = 24'h000000; `tick_o`, `rollover_o`, `set_err_o`, `alarm_o` = 0; alarm FSM in IDLE.
- Prescaler counts 0..`CLK_HZ-1` while `run_i`=1. On wrap it returns to 0 and the time advances by one second.
- BCD ripple: S0 0–9 → S1 0–5 → M0 0–9 → M1 0–5 → H0/H1 00–23. At 23:59:59 the time wraps to 00:00:00 and `rollover_o` pulses.
- Load validation: a load is valid only if S1≤5, M1≤5, every digit ≤9, and HH≤23.
  - Valid load: `time_o` ← `set_time_i` and the prescaler clears to 0.
  - Invalid load: time and prescaler are unchanged and `set_err_o` pulses.
- Priority: load beats a prescaler wrap in the same cycle. No tick is generated and the prescaler goes to 0.
- `run_i`=0: loads are still accepted and no ticks are generated.
- Alarm FSM:
  - IDLE → RINGING on an edge where the new time equals `alarm_time_i` and `alarm_en_i`=1.
  - RINGING → IDLE on `alarm_ack_i`, on `alarm_en_i`=0, or after 60 ticks spent in RINGING.
  - `alarm_o` = (state == RINGING).
  - An ack in the same cycle as the match leaves the FSM in IDLE.
  - A valid load that lands exactly on the alarm time does not trigger the alarm; only ticks trigger it.

## Timing
- Wrap edge E: the prescaler is at `CLK_HZ-1` with `run_i`=1 before E. After E, `time_o` shows the new value and `tick_o`=1 for exactly the cycle E→E+1. `rollover_o` follows the same timing.
- Tick period is exactly `CLK_HZ` cycles while `run_i` stays high. Dropping `run_i` stretches the current second by the number of cycles it is low.
- Load: `set_valid_i` sampled at edge N → `time_o` = `set_time_i` after N. The first tick after the load occurs `CLK_HZ` cycles later.
- `set_err_o` is high for the cycle after the rejected load edge.
- `alarm_o` rises on the same edge the matching time appears.
- Asserting `wb_rst_ni` low mid-second clears all outputs immediately (asynchronous). Counting restarts from 0 on the first edge after deassertion.

## Configuration
- Macro `WATCH_ALARM_EN`.
  - Defined: alarm ports, comparator, ring counter and FSM are present.
  - Undefined: the alarm ports are absent and no alarm logic is built. Timekeeping behaviour is identical in both builds.

## Structure
- Package `watch_pkg` holds:
  - the BCD time typedef (six 4-bit digits), the packing order, and `TIME_W`=24;
  - limits `SEC_MAX`, `MIN_MAX`, `HOUR_MAX`;
  - the alarm state enum (IDLE, RINGING) and `ALARM_RING_TICKS`=60.
- Sub-module `watch_bcd_counter`: two-digit BCD counter with a parameterised terminal value, `inc_i`/`load_i` inputs and a `carry_o` output. It is instantiated three times (seconds, minutes, hours).

## Test plan
- Reset with `CLK_HZ`=4, `run_i`=1 → `time_o`=000000; first `tick_o` 4 cycles after reset release, `time_o`=000001.
- Load 235958, run 8 cycles → 235959, then 000000 with `tick_o` and `rollover_o` high in the same cycle.
- Load 246000, then 125960 → `set_err_o` pulses for each; `time_o` is unchanged.
- Load asserted on the prescaler-wrap cycle → `time_o` = loaded value, no `tick_o`; next tick 4 cycles later.
- `run_i`=0 for 10 cycles mid-second → no tick; the second completes after the remaining cycles once `run_i` returns high.
- `WATCH_ALARM_EN` build: alarm 000005, load 000003 → `alarm_o` rises with 000005. Ack clears it; a second case without ack drops `alarm_o` after 60 ticks.

Source files
------------

// File: rtl/watch_pkg.sv
// Shared time types, digit limits and alarm state encoding for the watch timekeeper.
package watch_pkg;
    localparam int TIME_W           = 24;
    localparam int ALARM_RING_TICKS = 60;

    localparam logic [7:0] SEC_MAX  = 8'h59;
    localparam logic [7:0] MIN_MAX  = 8'h59;
    localparam logic [7:0] HOUR_MAX = 8'h23;

    // Packing, most significant digit first: {H1,H0,M1,M0,S1,S0}
    typedef struct packed {
        logic [3:0] h1;
        logic [3:0] h0;
        logic [3:0] m1;
        logic [3:0] m0;
        logic [3:0] s1;
        logic [3:0] s0;
    } bcd_time_t;

    typedef enum logic {
        IDLE    = 1'b0,
        RINGING = 1'b1
    } alarm_state_t;

    // Once the low digits are known to be <= 9, a plain binary compare of a BCD pair is a decimal compare.
    function automatic logic bcd_time_valid(input bcd_time_t t);
        logic lo_ok;
        lo_ok = (t.s0 <= 4'd9) && (t.m0 <= 4'd9) && (t.h0 <= 4'd9);
        return lo_ok
            && ({t.s1, t.s0} <= SEC_MAX)
            && ({t.m1, t.m0} <= MIN_MAX)
            && ({t.h1, t.h0} <= HOUR_MAX);
    endfunction
endpackage

// File: rtl/watch_bcd_counter.sv
// Two-digit BCD counter that wraps to 00 after MAX_VAL; a load takes priority over an increment.
module watch_bcd_counter
    import watch_pkg::*;
#(
    parameter logic [7:0] MAX_VAL = 8'h59
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_ni,
    input  logic       inc_i,
    input  logic       load_i,
    input  logic [7:0] load_val_i,
    output logic [7:0] val_o,
    output logic [7:0] val_nxt_o,
    output logic       carry_o
);
    logic [7:0] r_val;
    logic [7:0] w_inc_val;

    always_comb begin
        if (r_val == MAX_VAL)
            w_inc_val = 8'h00;
        else if (r_val[3:0] == 4'd9)
            w_inc_val = {r_val[7:4] + 4'd1, 4'd0};
        else
            w_inc_val = {r_val[7:4], r_val[3:0] + 4'd1};
    end

    always_comb begin
        if (load_i)
            val_nxt_o = load_val_i;
        else if (inc_i)
            val_nxt_o = w_inc_val;
        else
            val_nxt_o = r_val;
    end

    assign carry_o = inc_i && (r_val == MAX_VAL);
    assign val_o   = r_val;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni)
            r_val <= 8'h00;
        else
            r_val <= val_nxt_o;
    end
endmodule

// File: rtl/watch_timekeeper.sv
// 24-hour BCD time-of-day core with a 1 Hz prescaler and validated time load.
// Optional alarm comparator/FSM is built only when WATCH_ALARM_EN is defined.
//   state   | meaning
//   IDLE    | alarm silent, waiting for a tick that lands on the alarm time
//   RINGING | alarm_o high until ack, disarm, or ALARM_RING_TICKS ticks
module watch_timekeeper
    import watch_pkg::*;
#(
    parameter int CLK_HZ = 10_000_000
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    input  logic              run_i,
    input  logic              set_valid_i,
    input  logic [TIME_W-1:0] set_time_i,
    output logic              set_err_o,
    output logic [TIME_W-1:0] time_o,
    output logic              tick_o,
    output logic              rollover_o
`ifdef WATCH_ALARM_EN
    ,
    input  logic [TIME_W-1:0] alarm_time_i,
    input  logic              alarm_en_i,
    input  logic              alarm_ack_i,
    output logic              alarm_o
`endif
);
    localparam int              PW       = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0]   PRESC_TC = PW'(CLK_HZ - 1);

    logic [PW-1:0] r_presc;
    logic          r_tick;
    logic          r_roll;
    logic          r_err;

    logic       w_wrap;
    logic       w_set_ok;
    logic       w_inc;
    logic       w_sec_carry;
    logic       w_min_carry;
    logic       w_hr_carry;
    logic [7:0] w_sec;
    logic [7:0] w_min;
    logic [7:0] w_hr;
    logic [7:0] w_sec_nxt;
    logic [7:0] w_min_nxt;
    logic [7:0] w_hr_nxt;

    assign w_wrap   = run_i && (r_presc == PRESC_TC);
    assign w_set_ok = set_valid_i && bcd_time_valid(bcd_time_t'(set_time_i));
    // A valid load swallows a coincident wrap: the new second starts from the load.
    assign w_inc    = w_wrap && !w_set_ok;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_presc <= '0;
            r_tick  <= 1'b0;
            r_roll  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            if (w_set_ok || w_wrap)
                r_presc <= '0;
            else if (run_i)
                r_presc <= r_presc + PW'(1);
            r_tick <= w_inc;
            r_roll <= w_hr_carry;
            r_err  <= set_valid_i && !w_set_ok;
        end
    end

    watch_bcd_counter #(.MAX_VAL(SEC_MAX)) u_sec (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_ni  (wb_rst_ni),
        .inc_i      (w_inc),
        .load_i     (w_set_ok),
        .load_val_i (set_time_i[7:0]),
        .val_o      (w_sec),
        .val_nxt_o  (w_sec_nxt),
        .carry_o    (w_sec_carry)
    );

    watch_bcd_counter #(.MAX_VAL(MIN_MAX)) u_min (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_ni  (wb_rst_ni),
        .inc_i      (w_sec_carry),
        .load_i     (w_set_ok),
        .load_val_i (set_time_i[15:8]),
        .val_o      (w_min),
        .val_nxt_o  (w_min_nxt),
        .carry_o    (w_min_carry)
    );

    watch_bcd_counter #(.MAX_VAL(HOUR_MAX)) u_hr (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_ni  (wb_rst_ni),
        .inc_i      (w_min_carry),
        .load_i     (w_set_ok),
        .load_val_i (set_time_i[23:16]),
        .val_o      (w_hr),
        .val_nxt_o  (w_hr_nxt),
        .carry_o    (w_hr_carry)
    );

    assign time_o     = {w_hr, w_min, w_sec};
    assign tick_o     = r_tick;
    assign rollover_o = r_roll;
    assign set_err_o  = r_err;

`ifdef WATCH_ALARM_EN
    localparam logic [5:0] RING_LAST = 6'(ALARM_RING_TICKS - 1);

    alarm_state_t      r_state;
    logic [5:0]        r_ring_cnt;
    logic              r_alarm;
    logic [TIME_W-1:0] w_time_nxt;
    logic              w_match;

    // Compare against the post-edge time so alarm_o rises together with the matching time_o.
    assign w_time_nxt = {w_hr_nxt, w_min_nxt, w_sec_nxt};
    assign w_match    = w_inc && alarm_en_i && (w_time_nxt == alarm_time_i);

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state    <= IDLE;
            r_ring_cnt <= '0;
            r_alarm    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_match && !alarm_ack_i) begin
                        r_state    <= RINGING;
                        r_ring_cnt <= '0;
                        r_alarm    <= 1'b1;
                    end
                end
                RINGING: begin
                    if (alarm_ack_i || !alarm_en_i || (w_inc && (r_ring_cnt == RING_LAST))) begin
                        r_state <= IDLE;
                        r_alarm <= 1'b0;
                    end else if (w_inc) begin
                        r_ring_cnt <= r_ring_cnt + 6'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_alarm <= 1'b0;
                end
            endcase
        end
    end

    assign alarm_o = r_alarm;
`else
    logic w_unused_nxt;
    assign w_unused_nxt = ^{w_hr_nxt, w_min_nxt, w_sec_nxt};
`endif
endmodule
